rx_pkt_framer: RTL
==================

# rx_pkt_framer

Receive-side inband packet framer: the counterpart of the TX inband buffer, sitting between the per-channel RX sample FIFOs and the USB-bound packet FIFO. When a channel holds a full packet of samples, it emits one fixed 512-byte inband packet as 256 16-bit words through the WR / WR_done write handshake used by the channel RAMs. Each packet has a 4-word header carrying channel, length, flags and timestamp. Channels are served round-robin; overruns are latched and reported in the next header of that channel.

## Interface
- NUM_CHAN, 2, number of RX data channels (1..4)
- PAYLOAD_WORDS, 252, 16-bit payload words per packet; even, fixed so a packet is exactly 256 words
- rxclk  in  1  sole clock
- reset  in  1  synchronous, active-low
- enable  in  1  framer may start new packets
- timestamp_clock  in  32  free-running sample-time counter
- chan_pkt_ready  in  NUM_CHAN  sample FIFO n holds ≥ PAYLOAD_WORDS words
- chan_fifodata  in  16*NUM_CHAN  show-ahead FIFO heads; channel n at [16n+15:16n]
- chan_rdreq  out  NUM_CHAN  pop strobe, at most one bit high
- chan_overrun  in  NUM_CHAN  one-cycle overrun pulses from the sample path
- have_space  in  1  output FIFO can accept 256 words
- out_data  out  16  packet word
- out_WR  out  1  out_data valid this cycle
- out_WR_done  out  1  one-cycle end-of-packet pulse
- busy  out  1  high from grant until the WR_done cycle inclusive

## Operation
- Header word 0 (32 b): [31] overrun, [30] 0, [29] start-of-burst (1), [28] end-of-burst (1), [27:21] 0, [20:16] channel, [15:9] 0, [8:0] payload length in bytes (PAYLOAD_WORDS*2 = 504).
- Header word 1: timestamp_clock captured at grant.
- Each 32-bit header word goes out low half first.
- States:
  - IDLE → GRANT when reset high, enable, have_space and any chan_pkt_ready.
  - GRANT: latch the channel, timestamp and overrun bit, then clear the latch → H0L → H0H → H1L → H1H → PAYLOAD.
  - PAYLOAD: PAYLOAD_WORDS cycles → DONE.
  - DONE → IDLE.
- Arbitration is round-robin. Search starts at last_served+1 mod NUM_CHAN; last_served resets to NUM_CHAN-1, so channel 0 wins first.
- PAYLOAD: chan_rdreq[g] is high combinationally every cycle. out_data is registered from chan_fifodata[g] at the next edge, so the FIFO head is popped as it is captured.
- Overrun latch: a pulse sets the channel's sticky bit. The GRANT cycle clears the bit after copying it. A pulse coinciding with GRANT for the same channel leaves the bit set, and it is reported in the next packet.
- enable or have_space dropping mid-packet does not stall the packet; they are sampled only in IDLE.
- chan_pkt_ready dropping mid-packet is a source error; the framer does not check it.
- Reset mid-packet: return to IDLE immediately, no WR_done. The downstream channel_ram shares the reset.

## Timing
- Reset values: out_data=0, out_WR=0, out_WR_done=0, chan_rdreq=0, busy=0, overrun latches=0, state=IDLE.
- Grant decision: in IDLE, registered into GRANT at the next edge.
- out_WR runs high for exactly 256 consecutive cycles, starting the cycle after GRANT.
- out_WR_done pulses the cycle after the last out_WR.
- Packet occupancy: 259 cycles (GRANT + 256 + DONE + IDLE). Back-to-back packets are separated by 3 non-write cycles.
- chan_rdreq is asserted for exactly PAYLOAD_WORDS cycles per packet.

## Configuration
- RX_PKT_RSSI_EN defined:
  - Adds input rssi, 32*NUM_CHAN.
  - Header word 0 [26:21] = rssi of the granted channel, bits [5:0], captured at GRANT.
- Undefined: no rssi port; [26:21] = 0.

## Structure
- Package rx_pkt_pkg holds:
  - the state enum
  - header bit positions
  - constants HDR_WORDS=4 and PKT_WORDS=256
  - the PAYLOAD_WORDS+HDR_WORDS==PKT_WORDS consistency check
- One sub-module, rx_rr_arbiter:
  - Inputs: request vector and last_served.
  - Outputs: one-hot grant and its index; combinational.
  - Instantiated once.

## Test plan
- After reset, chan_pkt_ready=01, have_space=1, enable=1, timestamp_clock=0x1234 at grant, FIFO data 0..251 → 256 writes: 0x01F8 (word 0 low half: length 504, channel 0), 0x3000 (word 0 high half: SOB+EOB), 0x1234, 0x0000, then 0..251; WR_done one cycle later; chan_rdreq[0] high for exactly 252 cycles.
- chan_pkt_ready=11 held → packets alternate channel 0, 1, 0; header word 0 high/low halves carry [20:16]=0,1,0; gap of 3 non-write cycles between packets.
- Overrun pulse on channel 1 while channel 0 is being sent → next channel-1 header has word 0 bit 31 set; the following channel-1 header has it clear.
- Overrun pulse on channel 0 in the same cycle as channel 0's GRANT → that header has bit 31 = 0; the next channel-0 header has bit 31 = 1.
- have_space=0 with chan_pkt_ready=01 → no writes for 100 cycles; have_space→1 → grant within 1 cycle. Reset low at payload word 50 → out_WR=0 the next cycle, no WR_done, state IDLE.

Source files
------------

// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: shared definitions for the RX inband packet framer.
//   - framer FSM state encoding
//   - header word 0 bit positions
//   - packet geometry constants and the geometry consistency check
//   - header word 0 builder
package rx_pkt_pkg;

  localparam int HDR_WORDS = 4;    // two 32-bit header words, sent as 16-bit halves
  localparam int PKT_WORDS = 256;  // 512-byte packet

  localparam int DEF_PAYLOAD_WORDS = PKT_WORDS - HDR_WORDS;

  // Header word 0 layout
  localparam int HDR_OVR_BIT  = 31;
  localparam int HDR_SOB_BIT  = 29;
  localparam int HDR_EOB_BIT  = 28;
  localparam int HDR_RSSI_LSB = 21;
  localparam int HDR_RSSI_W   = 6;
  localparam int HDR_CHAN_LSB = 16;
  localparam int HDR_CHAN_W   = 5;
  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_LEN_W    = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_H0L,
    ST_H0H,
    ST_H1L,
    ST_H1H,
    ST_PAYLOAD,
    ST_DONE
  } state_e;

  // Payload plus header must fill the fixed packet exactly, and the byte
  // length has to fit the 9-bit length field.
  function automatic bit geom_ok(int pw);
    return (pw + HDR_WORDS == PKT_WORDS) && (pw % 2 == 0) && (pw * 2 < (1 << HDR_LEN_W));
  endfunction

  function automatic logic [31:0] hdr0_word(logic ovr, logic [HDR_CHAN_W-1:0] chan,
                                            logic [HDR_RSSI_W-1:0] rssi,
                                            logic [HDR_LEN_W-1:0] len);
    logic [31:0] w;
    w = '0;
    w[HDR_OVR_BIT] = ovr;
    w[HDR_SOB_BIT] = 1'b1;
    w[HDR_EOB_BIT] = 1'b1;
    w[HDR_RSSI_LSB +: HDR_RSSI_W] = rssi;
    w[HDR_CHAN_LSB +: HDR_CHAN_W] = chan;
    w[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return w;
  endfunction

endpackage

// File: rtl/rx_rr_arbiter.sv
// rx_rr_arbiter: combinational round-robin channel picker.
// Ports:
//   i_req  [NUM_CHAN]  channels requesting service
//   i_last [CW]        channel served last; search starts at i_last+1
//   o_gnt  [NUM_CHAN]  one-hot grant (all zero when nothing requests)
//   o_idx  [CW]        index of the granted channel
module rx_rr_arbiter #(
  parameter int NUM_CHAN = 2,
  parameter int CW       = 1
) (
  input  logic [NUM_CHAN-1:0] i_req,
  input  logic [CW-1:0]       i_last,
  output logic [NUM_CHAN-1:0] o_gnt,
  output logic [CW-1:0]       o_idx
);

  always_comb begin
    int  c;
    bit  found;
    c     = 0;
    found = 1'b0;
    o_gnt = '0;
    o_idx = '0;
    // Walk last+1, last+2, ... wrapping, so last itself is checked last.
    for (int i = 1; i <= NUM_CHAN; i++) begin
      c = (int'(i_last) + i) % NUM_CHAN;
      if (!found && i_req[c]) begin
        found    = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = CW'(c);
      end
    end
  end

endmodule

// File: rtl/rx_pkt_framer.sv
// rx_pkt_framer: builds fixed 256-word inband packets from per-channel RX
// sample FIFOs and writes them to the USB-bound packet FIFO.
// Optional feature macro: RX_PKT_RSSI_EN (adds rssi input, reported in
// header word 0 bits [26:21]).
// Ports:
//   rxclk            clock
//   reset            synchronous, active-low
//   enable           allow new packets (sampled in IDLE only)
//   timestamp_clock  sample-time counter, captured into header word 1
//   chan_pkt_ready   per-channel "FIFO holds a full payload"
//   chan_fifodata    show-ahead FIFO heads, 16 bits per channel
//   chan_rdreq       per-channel pop strobe (at most one high)
//   chan_overrun     per-channel overrun pulses, latched until reported
//   rssi             (RX_PKT_RSSI_EN only) 32 bits per channel
//   have_space       output FIFO can take a whole packet (IDLE only)
//   out_data/out_WR  packet word stream, 256 consecutive writes
//   out_WR_done      end-of-packet pulse, cycle after last write
//   busy             grant through WR_done cycle
module rx_pkt_framer
  import rx_pkt_pkg::*;
#(
  parameter int NUM_CHAN      = 2,
  parameter int PAYLOAD_WORDS = DEF_PAYLOAD_WORDS
) (
  input  logic                    rxclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [31:0]             timestamp_clock,
  input  logic [NUM_CHAN-1:0]     chan_pkt_ready,
  input  logic [16*NUM_CHAN-1:0]  chan_fifodata,
  output logic [NUM_CHAN-1:0]     chan_rdreq,
  input  logic [NUM_CHAN-1:0]     chan_overrun,
`ifdef RX_PKT_RSSI_EN
  input  logic [32*NUM_CHAN-1:0]  rssi,
`endif
  input  logic                    have_space,
  output logic [15:0]             out_data,
  output logic                    out_WR,
  output logic                    out_WR_done,
  output logic                    busy
);

  localparam int CW    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int CNT_W = $clog2(PAYLOAD_WORDS);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(PAYLOAD_WORDS - 1);
  localparam logic [HDR_LEN_W-1:0] LEN_B    = HDR_LEN_W'(PAYLOAD_WORDS * 2);

  if (!geom_ok(PAYLOAD_WORDS)) begin : g_bad_geom
    $error("rx_pkt_framer: PAYLOAD_WORDS must be even and fill the packet with the header");
  end
  if (NUM_CHAN < 1 || NUM_CHAN > 4) begin : g_bad_chan
    $error("rx_pkt_framer: NUM_CHAN must be 1..4");
  end

  state_e                r_state, w_next;
  logic [CW-1:0]         r_chan, r_last;
  logic [NUM_CHAN-1:0]   r_chan_oh;
  logic [NUM_CHAN-1:0]   r_ovr_latch;
  logic                  r_hdr_ovr;
  logic [31:0]           r_ts;
  logic [HDR_RSSI_W-1:0] r_rssi;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_go;
  logic                  w_pop;
  logic [NUM_CHAN-1:0]   w_gnt;
  logic [CW-1:0]         w_gidx;
  logic [NUM_CHAN-1:0]   w_ovr_clr;
  logic [15:0]           w_head;
  logic [31:0]           w_hdr0;
  logic [HDR_RSSI_W-1:0] w_rssi_sel;

  rx_rr_arbiter #(.NUM_CHAN(NUM_CHAN), .CW(CW)) u_arb (
    .i_req  (chan_pkt_ready),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gidx)
  );

  assign w_go   = enable && have_space && (|chan_pkt_ready);
  assign w_head = chan_fifodata[16*r_chan +: 16];
  assign w_hdr0 = hdr0_word(r_hdr_ovr, HDR_CHAN_W'(r_chan), r_rssi, LEN_B);

`ifdef RX_PKT_RSSI_EN
  assign w_rssi_sel = rssi[32*r_chan +: HDR_RSSI_W];
`else
  assign w_rssi_sel = '0;
`endif

  // ---- FSM: state register ----
  always_ff @(posedge rxclk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_go) w_next = ST_GRANT;
      ST_GRANT:   w_next = ST_H0L;
      ST_H0L:     w_next = ST_H0H;
      ST_H0H:     w_next = ST_H1L;
      ST_H1L:     w_next = ST_H1H;
      ST_H1H:     w_next = ST_PAYLOAD;
      ST_PAYLOAD: if (r_cnt == CNT_LAST) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // out_data is registered, so each pop happens in the cycle whose closing
  // edge captures the FIFO head: H1H loads payload word 0, and the final
  // PAYLOAD cycle only shows the last word without popping.
  // The pop is gated by reset so an aborted packet does not lose a sample.
  always_comb begin
    busy       = (r_state != ST_IDLE);
    w_pop      = reset && ((r_state == ST_H1H) ||
                           (r_state == ST_PAYLOAD && r_cnt != CNT_LAST));
    chan_rdreq = w_pop ? r_chan_oh : '0;
    w_ovr_clr  = (r_state == ST_GRANT) ? r_chan_oh : '0;
  end

  // ---- datapath ----
  always_ff @(posedge rxclk) begin
    if (!reset) begin
      out_data    <= '0;
      out_WR      <= 1'b0;
      out_WR_done <= 1'b0;
      r_chan      <= '0;
      r_chan_oh   <= '0;
      r_last      <= CW'(NUM_CHAN - 1);
      r_ovr_latch <= '0;
      r_hdr_ovr   <= 1'b0;
      r_ts        <= '0;
      r_rssi      <= '0;
      r_cnt       <= '0;
    end else begin
      // A pulse in the GRANT cycle wins over the clear, so it survives
      // into the next packet of that channel.
      r_ovr_latch <= (r_ovr_latch & ~w_ovr_clr) | chan_overrun;
      out_WR_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_chan    <= w_gidx;
            r_chan_oh <= w_gnt;
            r_last    <= w_gidx;
          end
        end
        ST_GRANT: begin
          r_ts      <= timestamp_clock;
          r_hdr_ovr <= r_ovr_latch[r_chan];
          r_rssi    <= w_rssi_sel;
          out_data  <= w_hdr0[15:0];   // low half holds only the length
          out_WR    <= 1'b1;
        end
        ST_H0L: out_data <= w_hdr0[31:16];
        ST_H0H: out_data <= r_ts[15:0];
        ST_H1L: out_data <= r_ts[31:16];
        ST_H1H: begin
          out_data <= w_head;
          r_cnt    <= '0;
        end
        ST_PAYLOAD: begin
          if (r_cnt == CNT_LAST) begin
            out_WR      <= 1'b0;
            out_WR_done <= 1'b1;
          end else begin
            out_data <= w_head;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
